input_debouncer: RTL
====================

# input_debouncer

Input conditioning stage that sits directly upstream of the lab's Moore state machines and produces their `A` input. A raw push-button or switch level is synchronised into the clock domain and debounced by a small state machine with a stability counter. The block outputs a clean level plus single-cycle rising and falling edge pulses. Downstream FSMs consume `A` as a stable level that changes at most once per bounce-free interval.

## Interface
- `STABLE_CYCLES`, default 4: consecutive synchronised samples required before `A` changes. Legal range 2..255.
- `CNT_W`, default 8: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately while 0
- `raw_in`  in  1  asynchronous raw switch/button level
- `A`  out  1  debounced level; feeds the downstream FSM `A` input
- `rise`  out  1  one-cycle pulse when `A` goes 0→1
- `fall`  out  1  one-cycle pulse when `A` goes 1→0

## Operation
- Synchroniser: two flops, `raw_in` → `s1` → `s2`. Both reset to 0.
- Debounce FSM has 4 states:
  - `LOW`: `A`=0. Stays while `s2`==0. On `s2`==1, go to `CHK_HIGH` with `cnt`=1.
  - `CHK_HIGH`: `A`=0.
    - `s2`==0 → `LOW`, `cnt`=0.
    - `s2`==1 and `cnt`==STABLE_CYCLES-1 → `HIGH`, `A`=1, `rise`=1, `cnt`=0.
    - Otherwise `cnt`+1.
  - `HIGH`: `A`=1. Stays while `s2`==1. On `s2`==0, go to `CHK_LOW` with `cnt`=1.
  - `CHK_LOW`: mirror of `CHK_HIGH`. Exit condition sets `A`=0 and `fall`=1.
- `cnt` is unsigned, CNT_W bits, and never exceeds STABLE_CYCLES-1. It cannot wrap.
- A single sample disagreeing with the candidate level aborts the check. There is no partial credit; the next check restarts at `cnt`=1.
- `rise` and `fall` are never high in the same cycle. Each lasts exactly one clock cycle.
- Reset values:
  - State `LOW`, `cnt`=0, `s1`=`s2`=0.
  - `A`=0, `rise`=0, `fall`=0.
- Reset mid-check discards the check. After release, a level held high on `raw_in` is debounced from scratch.

## Timing
- All outputs are registered; there is no combinational path from `raw_in` to any output.
- Let edge N be the first rising edge that samples the new `raw_in` value into `s1`:
  - `s2` updates at edge N+1.
  - The FSM enters `CHK_*` at edge N+2.
  - `A` changes at edge N+1+STABLE_CYCLES, provided `raw_in` stays stable.
- `rise`/`fall` assert at the same edge as the `A` change and deassert at the next edge.
- Pulses on `raw_in` shorter than STABLE_CYCLES clock periods (after synchronisation) never reach `A`.
- Reset assertion clears all outputs asynchronously, with no clock required. Deassertion is sampled; the first FSM evaluation occurs at the first rising edge after `reset` goes to 1.

## Structure
- Shared package `debounce_pkg` holds:
  - the 2-bit state typedef: `LOW`=00, `CHK_HIGH`=01, `HIGH`=11, `CHK_LOW`=10 (Gray ordering);
  - the default STABLE_CYCLES constant.
- One sub-module, `sync_2ff`: a two-flop synchroniser with asynchronous active-low clear, instantiated once. It is reusable for other switch inputs feeding the lab FSMs.
- Counter and FSM live in `input_debouncer` itself. No further hierarchy.

## Test plan
- **Reset:** hold `reset`=0 with `raw_in`=1 for 5 cycles → `A`=0, `rise`=0, `fall`=0 throughout. Release, keep `raw_in`=1 → `A`=1 at the 5th rising edge after release (first edge samples `s1`), with `rise` high for exactly one cycle.
- **Clean press:** STABLE_CYCLES=4. `raw_in` goes 0→1 and is first sampled at edge 10 → `A`=1 and `rise`=1 at edge 15. `rise`=0 at edge 16. `fall` stays 0.
- **Bounce reject:** STABLE_CYCLES=4. `raw_in` high for 3 cycles, low 2, high 3, then low → `A` stays 0; no `rise` or `fall` ever.
- **Bounce then settle:** `raw_in` 1,0,1,1,0 then held 1 (first sample at edge 20) → `A` rises exactly 5 edges after the final 0→1 sample.
- **Release:** from `A`=1, `raw_in` goes to 0, first sampled at edge 40 → `A`=0 and `fall`=1 at edge 45. `fall`=0 at edge 46.
- **Reset mid-check:** assert `reset` while in `CHK_HIGH` with `cnt`=2 → `A`=0 and state `LOW` immediately. After release, a full STABLE_CYCLES+1 edges are needed before `A`=1.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer and its users.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_pkg;

   // Gray-ordered so every legal transition flips exactly one state bit
   typedef enum logic [1:0] {
      LOW      = 2'b00,
      CHK_HIGH = 2'b01,
      HIGH     = 2'b11,
      CHK_LOW  = 2'b10
   } db_state_t;

   // Consecutive synchronised samples needed before the level is accepted
   localparam int DEFAULT_STABLE_CYCLES = 4;

   // Counter width; must hold STABLE_CYCLES-1
   localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clock domain.
// Latency: 2 rising edges from input change to q.
// Backpressure: none; samples d on every edge.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1;

   // First stage may go metastable; second stage gives it a full cycle to settle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         q  <= '0;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw switch level into A plus one-cycle rise/fall pulses.
// Latency: A changes STABLE_CYCLES+1 edges after raw_in is first sampled.
// Backpressure: none; samples raw_in every cycle, outputs are always valid.
module input_debouncer
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int CNT_W         = DEFAULT_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic A,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s2;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (raw_in),
      .q     (s2)
   );

   // Candidate level must be seen on STABLE_CYCLES consecutive samples; any
   // disagreeing sample aborts the check and the next one restarts at cnt=1
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= LOW;
         cnt   <= '0;
         A     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            LOW: begin
               if (s2) begin
                  state <= CHK_HIGH;
                  cnt   <= CNT_ONE;
               end
            end
            CHK_HIGH: begin
               if (!s2) begin
                  state <= LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= HIGH;
                  cnt   <= '0;
                  A     <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            HIGH: begin
               if (!s2) begin
                  state <= CHK_LOW;
                  cnt   <= CNT_ONE;
               end
            end
            CHK_LOW: begin
               if (s2) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= LOW;
                  cnt   <= '0;
                  A     <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= LOW;
               cnt   <= '0;
               A     <= 1'b0;
            end
         endcase
      end
   end

endmodule
